// File: rtl/word_entry_pkg.sv
// Shared types and helpers for the keypad word-entry front end.
package word_entry_pkg;

    typedef enum logic [1:0] {
        HOST_ENTRY = 2'd0,
        GUESS      = 2'd1,
        DONE       = 2'd2
    } entry_state_t;

    localparam logic [7:0] ASCII_A = 8'h41;

    // Letter index 0..25 to its upper-case ASCII code.
    function automatic logic [7:0] key_to_ascii(input logic [4:0] key);
        return ASCII_A + {3'b000, key};
    endfunction

endpackage

// File: rtl/letter_used_mask.sv
// 26-bit used-letter set: one bit per letter A..Z, set on demand,
// bulk clear, combinational membership query.
module letter_used_mask (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       set_i,
    input  logic [4:0] set_idx_i,
    input  logic [4:0] query_idx_i,
    output logic       used_o
);

    logic [25:0] mask_q;
    logic [25:0] mask_d;

    // Next mask: clear wins over set.
    always_comb begin
        mask_d = mask_q;
        if (clr_i) begin
            mask_d = '0;
        end else if (set_i && (set_idx_i <= 5'd25)) begin
            mask_d[set_idx_i] = 1'b1;
        end
    end

    // Mask register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign used_o = (query_idx_i <= 5'd25) ? mask_q[query_idx_i] : 1'b0;

endmodule

// File: rtl/word_entry_ctrl.sv
// Keypad front end: host enters the secret word, then each key press becomes
// a guess byte for the game logic. All outputs are registered.
// Optional: define DUP_GUESS_FILTER_EN to drop repeated guess letters and
// add the dup_flag output.
module word_entry_ctrl
    import word_entry_pkg::*;
#(
    parameter int         WORD_LEN   = 5,
    parameter logic [7:0] ASCII_BASE = 8'h41
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            key_code,
    input  logic                  key_strobe,
    input  logic                  backspace,
    input  logic                  enter,
    input  logic                  gameEnd,
    output logic [8*WORD_LEN-1:0] setWord,
    output logic [2:0]            word_len,
    output logic                  toggle_state,
    output logic [7:0]            guess,
    output logic                  guess_valid,
    output logic [1:0]            mode
`ifdef DUP_GUESS_FILTER_EN
    ,
    output logic                  dup_flag
`endif
);

    localparam logic [2:0] LEN_MAX = 3'(WORD_LEN);

    entry_state_t             state_q, state_d;
    logic [8*WORD_LEN-1:0]    word_q, word_d;
    logic [2:0]               len_q, len_d;
    logic [7:0]               guess_q, guess_d;
    logic                     toggle_q, toggle_d;
    logic                     gvalid_q, gvalid_d;
    logic                     key_ok;
    logic [7:0]               key_ascii;

    assign key_ok    = key_strobe && (key_code <= 5'd25);
    assign key_ascii = key_to_ascii(key_code) + (ASCII_BASE - ASCII_A);

`ifdef DUP_GUESS_FILTER_EN
    logic dup_q, dup_d;
    logic mask_set, mask_clr, letter_used;

    letter_used_mask u_mask (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (mask_clr),
        .set_i       (mask_set),
        .set_idx_i   (key_code),
        .query_idx_i (key_code),
        .used_o      (letter_used)
    );
`endif

    // Next state and next register values; enter outranks backspace outranks a letter.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        len_d    = len_q;
        guess_d  = guess_q;
        toggle_d = 1'b0;
        gvalid_d = 1'b0;
`ifdef DUP_GUESS_FILTER_EN
        dup_d    = 1'b0;
        mask_set = 1'b0;
        mask_clr = 1'b0;
`endif
        unique case (state_q)
            HOST_ENTRY: begin
                if (enter) begin
                    if (len_q == LEN_MAX) begin
                        toggle_d = 1'b1;
                        state_d  = GUESS;
                    end
                end else if (backspace) begin
                    if (len_q != 3'd0) begin
                        len_d = len_q - 3'd1;
                        for (int i = 0; i < WORD_LEN; i++) begin
                            if (len_q == 3'(i + 1)) word_d[8*(WORD_LEN-1-i) +: 8] = 8'h00;
                        end
                    end
                end else if (key_ok && (len_q < LEN_MAX)) begin
                    len_d = len_q + 3'd1;
                    for (int i = 0; i < WORD_LEN; i++) begin
                        if (len_q == 3'(i)) word_d[8*(WORD_LEN-1-i) +: 8] = key_ascii;
                    end
                end
            end
            GUESS: begin
                if (gameEnd) begin
                    state_d = DONE;
                end else if (!enter && !backspace && key_ok) begin
`ifdef DUP_GUESS_FILTER_EN
                    if (letter_used) begin
                        dup_d = 1'b1;
                    end else begin
                        guess_d  = key_ascii;
                        gvalid_d = 1'b1;
                        mask_set = 1'b1;
                    end
`else
                    guess_d  = key_ascii;
                    gvalid_d = 1'b1;
`endif
                end
            end
            DONE: begin
                if (enter) begin
                    word_d  = '0;
                    len_d   = 3'd0;
                    guess_d = 8'h00;
                    state_d = HOST_ENTRY;
`ifdef DUP_GUESS_FILTER_EN
                    mask_clr = 1'b1;
`endif
                end
            end
            default: state_d = HOST_ENTRY;
        endcase
    end

    // State and output registers; reset returns every output to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= HOST_ENTRY;
            word_q   <= '0;
            len_q    <= 3'd0;
            guess_q  <= 8'h00;
            toggle_q <= 1'b0;
            gvalid_q <= 1'b0;
`ifdef DUP_GUESS_FILTER_EN
            dup_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            len_q    <= len_d;
            guess_q  <= guess_d;
            toggle_q <= toggle_d;
            gvalid_q <= gvalid_d;
`ifdef DUP_GUESS_FILTER_EN
            dup_q    <= dup_d;
`endif
        end
    end

    assign setWord      = word_q;
    assign word_len     = len_q;
    assign toggle_state = toggle_q;
    assign guess        = guess_q;
    assign guess_valid  = gvalid_q;
    assign mode         = state_q;
`ifdef DUP_GUESS_FILTER_EN
    assign dup_flag     = dup_q;
`endif

endmodule

// File: tb/tb_word_entry_ctrl.sv
// Bench for word_entry_ctrl: directed vector table, random stimulus against a
// queue-based reference model, mid-operation reset and (optionally) the
// duplicate-guess filter.
module tb_word_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  key_code;
    logic        key_strobe, backspace, enter, gameEnd;
    logic [39:0] setWord;
    logic [2:0]  word_len;
    logic        toggle_state;
    logic [7:0]  guess;
    logic        guess_valid;
    logic [1:0]  mode;
`ifdef DUP_GUESS_FILTER_EN
    logic        dup_flag;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    word_entry_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .key_code     (key_code),
        .key_strobe   (key_strobe),
        .backspace    (backspace),
        .enter        (enter),
        .gameEnd      (gameEnd),
        .setWord      (setWord),
        .word_len     (word_len),
        .toggle_state (toggle_state),
        .guess        (guess),
        .guess_valid  (guess_valid),
        .mode         (mode)
`ifdef DUP_GUESS_FILTER_EN
        ,
        .dup_flag     (dup_flag)
`endif
    );

    // ---------------- reference model ----------------
    int        m_mode;          // 0 host entry, 1 guess, 2 done
    byte       m_letters[$];
    logic [7:0] m_guess;
    bit        m_toggle, m_gv, m_dup;
    bit        m_used[26];

    task automatic model_reset();
        m_mode = 0;
        m_letters.delete();
        m_guess = 8'h00;
        m_toggle = 0; m_gv = 0; m_dup = 0;
        foreach (m_used[i]) m_used[i] = 0;
    endtask

    task automatic model_step(input bit en, input bit bs, input bit ks,
                              input logic [4:0] kc, input bit ge);
        bit valid;
        valid = ks && (kc < 26);
        m_toggle = 0; m_gv = 0; m_dup = 0;
        if (m_mode == 0) begin
            if (en) begin
                if (m_letters.size() == 5) begin m_toggle = 1; m_mode = 1; end
            end else if (bs) begin
                if (m_letters.size() > 0) void'(m_letters.pop_back());
            end else if (valid && m_letters.size() < 5) begin
                m_letters.push_back(byte'(8'h41 + kc));
            end
        end else if (m_mode == 1) begin
            if (ge) m_mode = 2;
            else if (!en && !bs && valid) begin
`ifdef DUP_GUESS_FILTER_EN
                if (m_used[kc]) m_dup = 1;
                else begin m_guess = 8'h41 + kc; m_gv = 1; m_used[kc] = 1; end
`else
                m_guess = 8'h41 + kc; m_gv = 1;
`endif
            end
        end else begin
            if (en) begin
                m_letters.delete();
                m_guess = 8'h00;
                m_mode = 0;
                foreach (m_used[i]) m_used[i] = 0;
            end
        end
    endtask

    function automatic logic [39:0] model_word();
        logic [39:0] w;
        w = '0;
        for (int i = 0; i < m_letters.size(); i++) w[8*(4-i) +: 8] = m_letters[i];
        return w;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " mode"},         40'(mode),         40'(m_mode));
        chk({tag, " word_len"},     40'(word_len),     40'(m_letters.size()));
        chk({tag, " setWord"},      setWord,           model_word());
        chk({tag, " guess"},        40'(guess),        40'(m_guess));
        chk({tag, " toggle_state"}, 40'(toggle_state), 40'(m_toggle));
        chk({tag, " guess_valid"},  40'(guess_valid),  40'(m_gv));
`ifdef DUP_GUESS_FILTER_EN
        chk({tag, " dup_flag"},     40'(dup_flag),     40'(m_dup));
`endif
    endtask

    // Drive one cycle of inputs (from a negedge), let the DUT clock, return at the next negedge.
    task automatic step(input bit en, input bit bs, input bit ks,
                        input logic [4:0] kc, input bit ge);
        enter = en; backspace = bs; key_strobe = ks; key_code = kc; gameEnd = ge;
        @(posedge clk);
        model_step(en, bs, ks, kc, ge);
        @(negedge clk);
        enter = 0; backspace = 0; key_strobe = 0; gameEnd = 0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         en, bs, ks;
        logic [4:0] kc;
        bit         ge;
        logic [1:0] e_mode;
        logic [2:0] e_len;
        logic [39:0] e_word;
        logic [7:0] e_guess;
        bit         e_tog, e_gv;
    } vec_t;

    function automatic vec_t mk(bit en, bit bs, bit ks, logic [4:0] kc, bit ge,
                                logic [1:0] md, logic [2:0] ln, logic [39:0] w,
                                logic [7:0] g, bit tg, bit gv);
        vec_t v;
        v.en = en; v.bs = bs; v.ks = ks; v.kc = kc; v.ge = ge;
        v.e_mode = md; v.e_len = ln; v.e_word = w; v.e_guess = g; v.e_tog = tg; v.e_gv = gv;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        rst = 1'b1;
        key_code = 0; key_strobe = 0; backspace = 0; enter = 0; gameEnd = 0;
        model_reset();

        //                en bs ks  kc  ge  mode len word            guess  tog gv
        vecs.push_back(mk(0, 0, 1,  0,  0,  0,  1, 40'h4100000000, 8'h00, 0, 0)); // A
        vecs.push_back(mk(0, 0, 1, 15,  0,  0,  2, 40'h4150000000, 8'h00, 0, 0)); // P
        vecs.push_back(mk(0, 0, 1, 15,  0,  0,  3, 40'h4150500000, 8'h00, 0, 0)); // P
        vecs.push_back(mk(0, 0, 1, 11,  0,  0,  4, 40'h4150504C00, 8'h00, 0, 0)); // L
        vecs.push_back(mk(1, 0, 0,  0,  0,  0,  4, 40'h4150504C00, 8'h00, 0, 0)); // enter at 4: ignored
        vecs.push_back(mk(0, 0, 1,  4,  0,  0,  5, 40'h4150504C45, 8'h00, 0, 0)); // E
        vecs.push_back(mk(0, 0, 1, 25,  0,  0,  5, 40'h4150504C45, 8'h00, 0, 0)); // sixth letter: full
        vecs.push_back(mk(1, 0, 0,  0,  0,  1,  5, 40'h4150504C45, 8'h00, 1, 0)); // confirm
        vecs.push_back(mk(0, 0, 0,  0,  0,  1,  5, 40'h4150504C45, 8'h00, 0, 0)); // pulse ends
        vecs.push_back(mk(0, 0, 1,  2,  0,  1,  5, 40'h4150504C45, 8'h43, 0, 1)); // guess C
        vecs.push_back(mk(0, 0, 0,  0,  0,  1,  5, 40'h4150504C45, 8'h43, 0, 0)); // strobe ends
        vecs.push_back(mk(1, 0, 1,  5,  0,  1,  5, 40'h4150504C45, 8'h43, 0, 0)); // enter+key: neither
        vecs.push_back(mk(0, 1, 0,  0,  0,  1,  5, 40'h4150504C45, 8'h43, 0, 0)); // backspace ignored
        vecs.push_back(mk(0, 0, 1,  7,  0,  1,  5, 40'h4150504C45, 8'h48, 0, 1)); // guess H
        vecs.push_back(mk(0, 0, 1,  3,  1,  2,  5, 40'h4150504C45, 8'h48, 0, 0)); // gameEnd beats key
        vecs.push_back(mk(0, 0, 1,  4,  0,  2,  5, 40'h4150504C45, 8'h48, 0, 0)); // DONE ignores key
        vecs.push_back(mk(1, 0, 0,  0,  0,  0,  0, 40'h0000000000, 8'h00, 0, 0)); // restart
        vecs.push_back(mk(0, 0, 1,  0,  0,  0,  1, 40'h4100000000, 8'h00, 0, 0)); // A
        vecs.push_back(mk(0, 0, 1,  1,  0,  0,  2, 40'h4142000000, 8'h00, 0, 0)); // B
        vecs.push_back(mk(0, 1, 0,  0,  0,  0,  1, 40'h4100000000, 8'h00, 0, 0)); // backspace
        vecs.push_back(mk(0, 0, 1,  2,  0,  0,  2, 40'h4143000000, 8'h00, 0, 0)); // C
        vecs.push_back(mk(0, 1, 0,  0,  0,  0,  1, 40'h4100000000, 8'h00, 0, 0)); // bs 1
        vecs.push_back(mk(0, 1, 0,  0,  0,  0,  0, 40'h0000000000, 8'h00, 0, 0)); // bs 2
        vecs.push_back(mk(0, 1, 0,  0,  0,  0,  0, 40'h0000000000, 8'h00, 0, 0)); // bs on empty
        vecs.push_back(mk(0, 0, 1, 26,  0,  0,  0, 40'h0000000000, 8'h00, 0, 0)); // code 26 ignored
        vecs.push_back(mk(0, 1, 1,  3,  0,  0,  0, 40'h0000000000, 8'h00, 0, 0)); // bs beats key

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset mode",         40'(mode),         40'd0);
        chk("reset setWord",      setWord,           40'd0);
        chk("reset word_len",     40'(word_len),     40'd0);
        chk("reset guess",        40'(guess),        40'd0);
        chk("reset toggle_state", 40'(toggle_state), 40'd0);
        chk("reset guess_valid",  40'(guess_valid),  40'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].bs, vecs[i].ks, vecs[i].kc, vecs[i].ge);
            chk($sformatf("vec%0d mode", i),     40'(mode),         40'(vecs[i].e_mode));
            chk($sformatf("vec%0d len", i),      40'(word_len),     40'(vecs[i].e_len));
            chk($sformatf("vec%0d setWord", i),  setWord,           vecs[i].e_word);
            chk($sformatf("vec%0d guess", i),    40'(guess),        40'(vecs[i].e_guess));
            chk($sformatf("vec%0d toggle", i),   40'(toggle_state), 40'(vecs[i].e_tog));
            chk($sformatf("vec%0d gvalid", i),   40'(guess_valid),  40'(vecs[i].e_gv));
        end

        // Random stimulus against the reference model
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 11) == 0);
            check_model($sformatf("rnd%0d", n));
        end

        // Reset asserted mid-entry with three letters held
        pulse_reset();
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 2, 0);
        check_model("pre-reset");
        rst = 1'b1;
        #1;
        chk("midrst mode",         40'(mode),         40'd0);
        chk("midrst setWord",      setWord,           40'd0);
        chk("midrst word_len",     40'(word_len),     40'd0);
        chk("midrst guess",        40'(guess),        40'd0);
        chk("midrst toggle_state", 40'(toggle_state), 40'd0);
        chk("midrst guess_valid",  40'(guess_valid),  40'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

`ifdef DUP_GUESS_FILTER_EN
        // Repeated guess letter is dropped and flagged
        for (int k = 0; k < 5; k++) step(0, 0, 1, 5'(k), 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 12, 0);
        chk("dup first M gvalid", 40'(guess_valid), 40'd1);
        chk("dup first M guess",  40'(guess),       40'h4D);
        chk("dup first M flag",   40'(dup_flag),    40'd0);
        step(0, 0, 1, 12, 0);
        chk("dup second M gvalid", 40'(guess_valid), 40'd0);
        chk("dup second M flag",   40'(dup_flag),    40'd1);
        chk("dup second M guess",  40'(guess),       40'h4D);
        step(0, 0, 0, 0, 0);
        chk("dup flag clears", 40'(dup_flag), 40'd0);
        check_model("dup end");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
